// File: rtl/tdc_thermo_encoder.sv
// tdc_thermo_encoder: samples a CARRY4 tap chain, detects first-tap rising edges and emits fine popcount plus coarse count with valid/ready handshake; optional bubble filter via TDC_BUBBLE_FILTER_EN.
module tdc_thermo_encoder #(
  parameter int Ncarry4  = 2,
  parameter int COARSE_W = 16,
  localparam int NTAPS   = 4 * Ncarry4,
  localparam int FINE_W  = $clog2(NTAPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTAPS-1:0]    CO,
  input  logic                ready,
  output logic [FINE_W-1:0]   fine,
  output logic [COARSE_W-1:0] coarse,
  output logic                valid,
  output logic                overflow
);
  logic [NTAPS-1:0]    t1_q, t1_d, t2_q, t2_d, filt;
  logic                prev0_q, prev0_d, valid_q, valid_d, overflow_q, overflow_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d, coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d, pop;
  logic                hit, load;
`ifdef TDC_BUBBLE_FILTER_EN
  always_comb begin
    filt = t2_q;
    for (int i = 1; i < NTAPS - 1; i++)
      filt[i] = (t2_q[i-1] & t2_q[i]) | (t2_q[i-1] & t2_q[i+1]) | (t2_q[i] & t2_q[i+1]);
  end
`else
  assign filt = t2_q;
`endif
  always_comb begin
    pop = '0;
    for (int i = 0; i < NTAPS; i++) pop = pop + FINE_W'(filt[i]);
  end
  assign hit  = t2_q[0] & ~prev0_q;
  assign load = hit & (~valid_q | ready);
  always_comb begin
    t1_d       = CO;
    t2_d       = t1_q;
    prev0_d    = t2_q[0];
    cnt_d      = cnt_q + 1'b1;
    fine_d     = load ? pop : fine_q;
    coarse_d   = load ? cnt_q : coarse_q;
    valid_d    = load ? 1'b1 : (valid_q & ~ready);
    overflow_d = hit & valid_q & ~ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q       <= '0;
      t2_q       <= '0;
      prev0_q    <= 1'b0;
      cnt_q      <= '0;
      fine_q     <= '0;
      coarse_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      prev0_q    <= prev0_d;
      cnt_q      <= cnt_d;
      fine_q     <= fine_d;
      coarse_q   <= coarse_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end
  assign fine     = fine_q;
  assign coarse   = coarse_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// tb_tdc_thermo_encoder: directed vectors for tdc_thermo_encoder (Ncarry4=2, COARSE_W=16).
module tb_tdc_thermo_encoder;
  logic        clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [7:0]  co = '0;
  logic [3:0]  fine;
  logic [15:0] coarse, cyc = '0, hc;
  logic        valid, overflow;
  int          errors = 0, checks = 0;

  tdc_thermo_encoder #(.Ncarry4(2), .COARSE_W(16)) dut (
    .clk(clk), .rst(rst), .CO(co), .ready(ready),
    .fine(fine), .coarse(coarse), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1'b1;
  endtask

  task automatic zeros();
    co = '0;
    repeat (3) tick();
  endtask

  task automatic hit_vec(input logic [7:0] code, input logic [3:0] ef);
    zeros();
    co = code;
    tick();
    tick();
    hc = cyc;
    check("pre_valid", valid, 0);
    tick();
    check("valid", valid, 1);
    check("fine", fine, ef);
    check("coarse", coarse, hc);
    check("ovf", overflow, 0);
    tick();
    check("valid_clr", valid, 0);
  endtask

  initial begin
    logic [3:0] bub;
    rst = 1'b1;
    tick();
    cyc = '0;
    check("rst_fine", fine, 0);
    check("rst_coarse", coarse, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    hit_vec(8'h0F, 4);
    tick();
    check("held_no_rehit", valid, 0);
`ifdef TDC_BUBBLE_FILTER_EN
    bub = 4;
`else
    bub = 3;
`endif
    hit_vec(8'h0D, bub);
    hit_vec(8'hFF, 8);
    hit_vec(8'h01, 1);
    // overflow scenario: hold ready low across two hits
    ready = 1'b0;
    zeros();
    co = 8'h03;
    tick();
    tick();
    hc = cyc;
    tick();
    check("ov_valid1", valid, 1);
    check("ov_fine1", fine, 2);
    zeros();
    check("ov_hold_valid", valid, 1);
    check("ov_hold_fine", fine, 2);
    co = 8'h07;
    tick();
    tick();
    check("ov_pre", overflow, 0);
    tick();
    check("ov_pulse", overflow, 1);
    check("ov_valid", valid, 1);
    check("ov_fine_hold", fine, 2);
    check("ov_coarse_hold", coarse, hc);
    tick();
    check("ov_one_cycle", overflow, 0);
    zeros();
    co = 8'h3F;
    tick();
    tick();
    ready = 1'b1;
    hc = cyc;
    tick();
    check("rl_valid", valid, 1);
    check("rl_fine", fine, 6);
    check("rl_coarse", coarse, hc);
    check("rl_ovf", overflow, 0);
    tick();
    check("rl_clr", valid, 0);
    // counter wrap with hits on both sides
    while (cyc != 16'hFFF0) tick();
    hit_vec(8'h0F, 4);
    hit_vec(8'h07, 3);
    hit_vec(8'h1F, 5);
    check("wrapped", coarse < 16'h0100, 1);
    // reset flush with valid pending and a hit in t1/t2
    ready = 1'b0;
    zeros();
    co = 8'h01;
    repeat (3) tick();
    check("fl_valid_pre", valid, 1);
    zeros();
    co = 8'h0F;
    tick();
    tick();
    rst = 1'b1;
    co = '0;
    tick();
    cyc = '0;
    check("fl_fine", fine, 0);
    check("fl_coarse", coarse, 0);
    check("fl_valid", valid, 0);
    check("fl_ovf", overflow, 0);
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_no_valid", valid, 0);
    end
    // first tap already high when reset releases
    co = 8'h0F;
    rst = 1'b1;
    tick();
    cyc = '0;
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_valid", valid, 1);
    check("post_rst_fine", fine, 4);
    check("post_rst_coarse", coarse, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
